// File: rtl/dm_arbiter_if.sv
// Requester and data-memory signal bundle for dm_arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface dm_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wd0, wd1;
  logic              gnt0, gnt1;
  logic              done0, done1;
  logic              err0, err1;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wd0, wd1, mem_rdata,
    output gnt0, gnt1, done0, done1, err0, err1, rdata,
           mem_addr, mem_wd, mem_we, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wd0, wd1, mem_rdata,
    input  gnt0, gnt1, done0, done1, err0, err1, rdata,
           mem_addr, mem_wd, mem_we, busy
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port arbiter for the shared data memory: IDLE -> ACCESS -> RESP per transaction.
// Define DM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 wins ties.
module dm_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  dm_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wd;
  } txn_t;

  state_t            state_q, state_d;
  logic              win_q, win_d;
  txn_t              txn_q, txn_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              any_req, pick;
  logic              in_acc, in_resp, misal;

`ifdef DM_ARB_RR_EN
  logic last_q, last_d;

  // On a tie, port 1 wins only if port 0 took the previous grant.
  always_comb begin
    pick = bus.req1 & (~bus.req0 | ~last_q);
  end
`else
  always_comb begin
    pick = ~bus.req0;
  end
`endif

  always_comb begin
    any_req = bus.req0 | bus.req1;
    state_d = state_q;
    win_d   = win_q;
    txn_d   = txn_q;
    rdata_d = rdata_q;
`ifdef DM_ARB_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      ACCESS: begin
        state_d = RESP;
        if (!txn_q.we) rdata_d = bus.mem_rdata;
      end
      default: begin
        // IDLE and RESP both arbitrate, giving back-to-back transactions.
        if (any_req) begin
          state_d = ACCESS;
          win_d   = pick;
          txn_d   = pick ? '{we: bus.we1, addr: bus.addr1, wd: bus.wd1}
                         : '{we: bus.we0, addr: bus.addr0, wd: bus.wd0};
`ifdef DM_ARB_RR_EN
          last_d  = pick;
`endif
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      txn_q   <= '0;
      rdata_q <= '0;
`ifdef DM_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      txn_q   <= txn_d;
      rdata_q <= rdata_d;
`ifdef DM_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  // Outputs decode straight from flops, so async reset clears mem_we at once.
  always_comb begin
    in_acc  = (state_q == ACCESS);
    in_resp = (state_q == RESP);
    misal   = (txn_q.addr[1:0] != 2'b00);
  end

  assign bus.gnt0     = in_acc & ~win_q;
  assign bus.gnt1     = in_acc &  win_q;
  assign bus.done0    = in_resp & ~win_q;
  assign bus.done1    = in_resp &  win_q;
  assign bus.err0     = in_resp & ~win_q & txn_q.we & misal;
  assign bus.err1     = in_resp &  win_q & txn_q.we & misal;
  assign bus.rdata    = rdata_q;
  assign bus.mem_addr = in_acc ? txn_q.addr : '0;
  assign bus.mem_wd   = in_acc ? txn_q.wd : '0;
  assign bus.mem_we   = in_acc & txn_q.we & ~misal;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: transaction-level schedule model compared every cycle,
// plus directed vectors with literal expectations.
module tb_dm_arbiter;
  logic clk;
  logic rst_n;
  dm_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dm_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return 32'hA5000000 ^ (32'(i) * 32'h00010203);
  endfunction

  // Data memory: synchronous write, combinational read.
  logic [31:0] mem [1024];
  logic [31:0] refmem [1024];
  initial for (int i = 0; i < 1024; i++) begin
    mem[i]    = init_word(i);
    refmem[i] = init_word(i);
  end
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[11:2]] <= bus.mem_wd;
  assign bus.mem_rdata = mem[bus.mem_addr[11:2]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Model: each accepted request owns cycle t_start (grant/memory phase) and
  // t_start+1 (done phase); the next arbitration happens at edge t_start+2.
  int          cyc     = 0;
  int          t_start = -10;
  int          free_at = 0;
  int          t_port  = 0;
  logic        t_we    = 1'b0;
  logic [31:0] t_addr  = '0;
  logic [31:0] t_wd    = '0;
  logic [31:0] exp_rdata = '0;
  int          last_w  = 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_start   = -10;
      free_at   = 0;
      exp_rdata = '0;
      last_w    = 1;
    end else begin
      cyc++;
      if (cyc == t_start + 1) begin
        if (t_we) begin
          if (t_addr[1:0] == 2'b00) refmem[t_addr[11:2]] = t_wd;
        end else begin
          exp_rdata = refmem[t_addr[11:2]];
        end
      end
      if (cyc >= free_at && (bus.req0 || bus.req1)) begin
        int w;
        if (bus.req0 && bus.req1) begin
`ifdef DM_ARB_RR_EN
          w = 1 - last_w;
`else
          w = 0;
`endif
        end else begin
          w = bus.req1 ? 1 : 0;
        end
        t_port  = w;
        t_we    = (w == 1) ? bus.we1 : bus.we0;
        t_addr  = (w == 1) ? bus.addr1 : bus.addr0;
        t_wd    = (w == 1) ? bus.wd1 : bus.wd0;
        t_start = cyc;
        free_at = cyc + 2;
        last_w  = w;
      end
    end
  end

  int gq[$];

  always @(negedge clk) begin
    if (rst_n) begin
      logic g, d, e;
      g = (cyc == t_start);
      d = (cyc == t_start + 1);
      e = d && t_we && (t_addr[1:0] != 2'b00);
      chk("gnt0",     32'(bus.gnt0),  32'(g && t_port == 0));
      chk("gnt1",     32'(bus.gnt1),  32'(g && t_port == 1));
      chk("done0",    32'(bus.done0), 32'(d && t_port == 0));
      chk("done1",    32'(bus.done1), 32'(d && t_port == 1));
      chk("err0",     32'(bus.err0),  32'(e && t_port == 0));
      chk("err1",     32'(bus.err1),  32'(e && t_port == 1));
      chk("busy",     32'(bus.busy),  32'(cyc < free_at));
      chk("mem_we",   32'(bus.mem_we), 32'(g && t_we && t_addr[1:0] == 2'b00));
      chk("mem_addr", bus.mem_addr, g ? t_addr : 32'h0);
      chk("mem_wd",   bus.mem_wd,   g ? t_wd : 32'h0);
      chk("rdata",    bus.rdata,    exp_rdata);
      if (bus.gnt0) gq.push_back(0);
      if (bus.gnt1) gq.push_back(1);
    end
  end

  task automatic set_req(input int p, input logic v, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin bus.req0 = v; bus.we0 = we; bus.addr0 = a; bus.wd0 = d; end
    else        begin bus.req1 = v; bus.we1 = we; bus.addr1 = a; bus.wd1 = d; end
  endtask

  task automatic wait_gnt(input int p, output int n);
    logic g;
    n = 0;
    g = 1'b0;
    while (!g && n < 10) begin
      @(negedge clk);
      n++;
      g = (p == 1) ? bus.gnt1 : bus.gnt0;
    end
    chk("gnt_seen", 32'(g), 32'd1);
  endtask

  // One transaction from an idle requester; returns latency, rdata and err.
  task automatic txn(input int p, input logic we, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic er, output int n);
    @(negedge clk);
    set_req(p, 1'b1, we, a, d);
    wait_gnt(p, n);
    set_req(p, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("done_next", 32'((p == 1) ? bus.done1 : bus.done0), 32'd1);
    rd = bus.rdata;
    er = (p == 1) ? bus.err1 : bus.err0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          n;
    rst_n = 1'b0;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wd0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wd1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt",   32'({bus.gnt0, bus.gnt1}), 32'd0);
    chk("rst_done",  32'({bus.done0, bus.done1}), 32'd0);
    chk("rst_err",   32'({bus.err0, bus.err1}), 32'd0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_mem",   bus.mem_addr | bus.mem_wd | 32'(bus.mem_we), 32'h0);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    rst_n = 1'b1;

    // Reset asserted during a store's ACCESS cycle must suppress the write.
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 32'h10, 32'hCAFEF00D);
    wait_gnt(0, n);
    chk("rst_pre_we", 32'(bus.mem_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_we",   32'(bus.mem_we), 32'd0);
    chk("rst_mid_gnt",  32'(bus.gnt0), 32'd0);
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_addr", bus.mem_addr, 32'h0);
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("rst_mid_word4", mem[4], init_word(4));
    @(negedge clk);
    rst_n = 1'b1;

    // Aligned store then load on port 0.
    txn(0, 1'b1, 32'h20, 32'hDEADBEEF, rd, er, n);
    chk("st_lat", 32'(n), 32'd1);
    chk("st_err", 32'(er), 32'd0);
    txn(0, 1'b0, 32'h20, 32'h0, rd, er, n);
    chk("ld_lat",   32'(n), 32'd1);
    chk("ld_rdata", rd, 32'hDEADBEEF);

    // Misaligned store on port 1 is dropped and flagged; misaligned load is fine.
    txn(1, 1'b1, 32'h42, 32'h12345678, rd, er, n);
    chk("mis_st_err",  32'(er), 32'd1);
    chk("mis_st_rd",   rd, 32'hDEADBEEF);
    chk("mis_word40",  mem[16], init_word(16));
    txn(1, 1'b0, 32'h42, 32'h0, rd, er, n);
    chk("mis_ld_err",  32'(er), 32'd0);
    chk("mis_ld_data", rd, init_word(16));

    // Port 1 request raised during port 0 RESP goes straight to ACCESS.
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 32'h20, 32'h0);
    wait_gnt(0, n);
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("b2b_done0", 32'(bus.done0), 32'd1);
    set_req(1, 1'b1, 1'b0, 32'h44, 32'h0);
    @(negedge clk);
    chk("b2b_gnt1", 32'(bus.gnt1), 32'd1);
    chk("b2b_busy", 32'(bus.busy), 32'd1);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("b2b_done1", 32'(bus.done1), 32'd1);
    chk("b2b_rdata", bus.rdata, init_word(17));

    // Both ports requesting continuously from a fresh reset.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    gq.delete();
    set_req(0, 1'b1, 1'b0, 32'h20, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h40, 32'h0);
    repeat (8) begin
      @(negedge clk);
      chk("sim_busy", 32'(bus.busy), 32'd1);
    end
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    chk("sim_count", 32'(gq.size()), 32'd4);
    for (int i = 0; i < gq.size() && i < 4; i++) begin
`ifdef DM_ARB_RR_EN
      chk("sim_order", 32'(gq[i]), 32'(i % 2));
`else
      chk("sim_order", 32'(gq[i]), 32'd0);
`endif
    end
    chk("sim_idle", 32'(bus.busy), 32'd0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port request/grant arbiter that shares the single-ported 1024-word data memory between the CPU load/store port (port 0) and a secondary master (port 1: loader/DMA/debug). It sequences each access as a fixed three-phase transaction, drives the memory's address, write-data and write-enable inputs, and returns registered read data with a done pulse. It sits between the requesters and the data memory; the memory's combinational read output feeds back into it.

## Interface
- ADDR_W, 32, byte-address width passed to memory
- DATA_W, 32, data word width

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  access request; held with we/addr/wd stable until gnt seen
- we0 / we1  in  1  1 = store, 0 = load
- addr0 / addr1  in  ADDR_W  byte address
- wd0 / wd1  in  DATA_W  store data
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted
- done0 / done1  out  1  one-cycle pulse: access complete, rdata/err valid
- err0 / err1  out  1  valid with done: misaligned store suppressed
- rdata  out  DATA_W  registered load data, shared by both ports
- mem_addr  out  ADDR_W  to memory address
- mem_wd  out  DATA_W  to memory write data
- mem_we  out  1  to memory write enable
- mem_rdata  in  DATA_W  memory combinational read data
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ACCESS, RESP. Reset state IDLE.
- IDLE: req0/req1 sampled at rising edge. None -> stay. One -> that port wins. Both -> winner per priority rule (Configuration). On win: latch we/addr/wd into txn registers, record winner, go ACCESS.
- ACCESS (exactly one cycle): gnt of winner = 1; mem_addr = latched addr, mem_wd = latched wd, mem_we = latched we AND addr[1:0]==0. Requests not sampled. At the ending edge: memory commits write; rdata <= mem_rdata (loads only; stores leave rdata unchanged); go RESP.
- RESP (one cycle): done of winner = 1; err of winner = 1 iff store with addr[1:0]!=0. At the ending edge requests are sampled exactly as in IDLE: winner -> ACCESS (back-to-back), else -> IDLE.
- Misaligned loads are not errors; memory ignores addr[1:0].
- Outside ACCESS: mem_addr = 0, mem_wd = 0, mem_we = 0.
- Requester drops req in the cycle after seeing gnt; a still-high req sampled in RESP counts as a new request.

## Timing
- Reset (async assert, sync release): state IDLE, all gnt/done/err 0, rdata 0, mem_we/mem_addr/mem_wd 0, busy 0, priority pointer = port 1 (port 0 wins first tie). Reset mid-ACCESS drops mem_we immediately: no write.
- Latency: req sampled at edge N -> gnt during cycle N..N+1 (ACCESS) -> done/rdata valid cycle N+1..N+2 (RESP).
- Throughput: one transaction per 2 cycles under continuous requests.
- gnt0/gnt1 and done0/done1 never both high; gnt and done never high together for the same port.
- rdata holds value until next load completes.

## Configuration
- DM_ARB_RR_EN defined: round-robin. Tie goes to port that did not win the last granted transaction; pointer updates on every grant.
- Not defined: fixed priority, port 0 always wins ties; pointer logic absent.

## Test plan
- Reset: rst_n low mid-ACCESS with we0=1, addr0=0x10 -> mem_we falls immediately, memory word 4 unchanged, all outputs 0.
- Single store then load on port 0: store 0xDEADBEEF at 0x20, then load 0x20 -> gnt0 one cycle after req, done0 next cycle, rdata=0xDEADBEEF.
- Simultaneous requests, DM_ARB_RR_EN: req0 and req1 held high for four transactions -> grant order 0,1,0,1, back-to-back every 2 cycles, busy constantly 1.
- Simultaneous requests, no macro: same stimulus -> port 0 granted every time, port 1 starved while req0 high.
- Misaligned store: port 1 store 0x12345678 to 0x42 -> mem_we stays 0, done1 and err1 high together, word 0x40 unchanged; misaligned load from 0x42 returns word 0x40 with err1=0.
- Back-to-back: port 1 request arriving during port 0 RESP -> port 1 ACCESS immediately after RESP, no IDLE cycle.
